ascii_dec_receiver: RTL and testbench

//  Receive-side counterpart of the ASCII sender path. Pops bytes from the UART controller RX FIFO
//  and parses decimal ASCII lines ("123\r") into an unsigned DATA_W-bit value.

---
 rtl/ascii_dec_receiver.sv | 186 ++++++++++++++++++
 tb/tb_ascii_dec_receiver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ascii_dec_receiver.sv
// ---------------------------------------------------------------------------
// ascii_dec_receiver
//   Pops bytes from a first-word-fall-through UART RX FIFO and parses decimal
//   ASCII lines ("123\r") into an unsigned DATA_W-bit value. A good line
//   produces a one-cycle o_valid pulse with o_data updated in the same cycle.
//   A malformed line produces a one-cycle o_err pulse. Malformed means a
//   non-digit byte, too many digits, or a value above 2**DATA_W-1.
//
//   Optional feature: define ECHO_EN to echo every popped byte to the TX
//   FIFO. The echo push is registered one cycle after the pop. Popping is
//   stalled while the TX FIFO is full.
//
// Parameters
//   DATA_W      width of the parsed value
//   MAX_DIGITS  max digit characters per line (leading zeros included)
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   rx_empty      RX FIFO empty
//   rx_pop_data   RX FIFO head byte (valid while rx_empty = 0)
//   rx_pop        pop strobe (combinational)
//   o_data        last good value, held until the next good line
//   o_valid       one-cycle pulse on a good line
//   o_err         one-cycle pulse on a rejected line
//   tx_full       TX FIFO full (ECHO_EN only)
//   tx_push       echo push strobe (0 without ECHO_EN)
//   tx_push_data  echo byte (0 without ECHO_EN)
// ---------------------------------------------------------------------------
module ascii_dec_receiver #(
  parameter int DATA_W     = 10,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [7:0]        rx_pop_data,
  output logic              rx_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_err,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [7:0]        tx_push_data
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  // Four spare bits hold acc*10 + 9 without wrapping, so overflow is visible.
  localparam int ACC_W = DATA_W + 4;
  localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {DATA_W{1'b1}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_SKIP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              is_digit;
  logic              is_term;
  logic [ACC_W-1:0]  digit_w;
  logic [ACC_W-1:0]  acc_n;

`ifdef ECHO_EN
  logic       tx_push_q, tx_push_d;
  logic [7:0] tx_data_q, tx_data_d;

  // Stall the pop while TX is full so that no echo byte is dropped.
  assign rx_pop = ~rx_empty & ~tx_full;

  always_comb begin
    tx_push_d = rx_pop;
    tx_data_d = rx_pop ? rx_pop_data : tx_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_push_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_push_q <= tx_push_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_push      = tx_push_q;
  assign tx_push_data = tx_data_q;
`else
  logic unused_tx_full;

  assign unused_tx_full = tx_full;
  assign rx_pop         = ~rx_empty;
  assign tx_push        = 1'b0;
  assign tx_push_data   = 8'h00;
`endif

  assign is_digit = (rx_pop_data >= 8'h30) && (rx_pop_data <= 8'h39);
  assign is_term  = (rx_pop_data == 8'h0D) || (rx_pop_data == 8'h0A);
  assign digit_w  = {{(ACC_W-4){1'b0}}, rx_pop_data[3:0]};
  assign acc_n    = {4'b0000, acc_q} * ACC_W'(10) + digit_w;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (rx_pop) begin
      case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            acc_d   = DATA_W'(rx_pop_data[3:0]);
            cnt_d   = CNT_W'(1);
            state_d = S_NUM;
          end else if (!is_term) begin
            state_d = S_SKIP;
          end
          // A terminator here is an empty line or the LF of a CRLF pair.
        end
        S_NUM: begin
          if (is_digit) begin
            if (cnt_q == CNT_W'(MAX_DIGITS) || acc_n > MAX_VAL) begin
              state_d = S_SKIP;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = acc_n[DATA_W-1:0];
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            data_d  = acc_q;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_SKIP;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        S_SKIP: begin
          if (is_term) begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_ascii_dec_receiver.sv
module tb_ascii_dec_receiver;

  logic       clk;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_pop_data;
  logic       tx_full;

  logic       rx_pop10, o_valid10, o_err10, tx_push10;
  logic [9:0] o_data10;
  logic [7:0] tx_push_data10;

  logic       rx_pop8, o_valid8, o_err8, tx_push8;
  logic [7:0] o_data8;
  logic [7:0] tx_push_data8;

  ascii_dec_receiver #(.DATA_W(10), .MAX_DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_pop_data(rx_pop_data),
    .rx_pop(rx_pop10), .o_data(o_data10), .o_valid(o_valid10), .o_err(o_err10),
    .tx_full(tx_full), .tx_push(tx_push10), .tx_push_data(tx_push_data10)
  );

  ascii_dec_receiver #(.DATA_W(8), .MAX_DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_pop_data(rx_pop_data),
    .rx_pop(rx_pop8), .o_data(o_data8), .o_valid(o_valid8), .o_err(o_err8),
    .tx_full(tx_full), .tx_push(tx_push8), .tx_push_data(tx_push_data8)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Pulse counters sampled on the active edge (pre-update values).
  int nv10, ne10, nv8, ne8, nboth;
  always @(posedge clk) begin
    if (o_valid10) nv10++;
    if (o_err10) ne10++;
    if (o_valid8) nv8++;
    if (o_err8) ne8++;
    if ((o_valid10 && o_err10) || (o_valid8 && o_err8)) nboth++;
  end

  typedef struct {
    logic [47:0] bytes;   // first byte in the top byte
    int          n;
    int          v10, e10, d10;
    int          v8, e8, d8;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the following falling edge.
  task automatic feed(input logic [7:0] b);
    rx_empty    = 1'b0;
    rx_pop_data = b;
    #1;
    check("rx_pop10 on byte", int'(rx_pop10), 1);
    check("rx_pop8 on byte", int'(rx_pop8), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rx_empty = 1'b1;
    #1;
    check("rx_pop10 idle", int'(rx_pop10), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sv10, se10, sv8, se8;
    clk = 1'b0; rst = 1'b1; rx_empty = 1'b1; rx_pop_data = 8'h00; tx_full = 1'b0;
    n_cmp = 0; n_bad = 0;
    nv10 = 0; ne10 = 0; nv8 = 0; ne8 = 0; nboth = 0;

    tbl[0]  = '{{"123", 8'h0D, 16'h0},        4, 1, 0, 123, 1, 0, 123};
    tbl[1]  = '{{"1234", 8'h0D, 8'h0},        5, 0, 1, 123, 0, 1, 123};
    tbl[2]  = '{{"007", 8'h0D, 8'h0A, 8'h0},  5, 1, 0, 7,   1, 0, 7};
    tbl[3]  = '{{"4X5", 8'h0D, 16'h0},        4, 0, 1, 7,   0, 1, 7};
    tbl[4]  = '{{"9", 8'h0D, 32'h0},          2, 1, 0, 9,   1, 0, 9};
    tbl[5]  = '{{"256", 8'h0D, 16'h0},        4, 1, 0, 256, 0, 1, 9};
    tbl[6]  = '{{"255", 8'h0D, 16'h0},        4, 1, 0, 255, 1, 0, 255};
    tbl[7]  = '{{"999", 8'h0D, 16'h0},        4, 1, 0, 999, 0, 1, 255};
    tbl[8]  = '{{"0", 8'h0D, 32'h0},          2, 1, 0, 0,   1, 0, 0};
    tbl[9]  = '{{8'h0D, 8'h0A, 32'h0},        2, 0, 0, 0,   0, 0, 0};
    tbl[10] = '{{"X", 8'h0D, 32'h0},          2, 0, 1, 0,   0, 1, 0};
    tbl[11] = '{{"300", 8'h0D, 16'h0},        4, 1, 0, 300, 0, 1, 0};
    tbl[12] = '{{"0012", 8'h0D, 8'h0},        5, 0, 1, 300, 0, 1, 0};
    tbl[13] = '{{"42", 8'h0A, 24'h0},         3, 1, 0, 42,  1, 0, 42};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst o_data10", int'(o_data10), 0);
    check("rst o_valid10", int'(o_valid10), 0);
    check("rst o_err10", int'(o_err10), 0);
    check("rst tx_push10", int'(tx_push10), 0);
    check("rst o_data8", int'(o_data8), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency with an empty gap mid-line
    feed("4");
    feed("2");
    check("lat no early valid", int'(o_valid10), 0);
    repeat (3) idle();
    check("gap no valid", int'(o_valid10), 0);
    feed(8'h0D);
    check("lat valid", int'(o_valid10), 1);
    check("lat data", int'(o_data10), 42);
    check("lat err", int'(o_err10), 0);
    idle();
    check("lat pulse width", int'(o_valid10), 0);

    // Back-to-back lines
    feed("1");
    feed(8'h0D);
    check("b2b valid1", int'(o_valid10), 1);
    check("b2b data1", int'(o_data10), 1);
    feed("2");
    check("b2b gap", int'(o_valid10), 0);
    feed(8'h0D);
    check("b2b valid2", int'(o_valid10), 1);
    check("b2b data2", int'(o_data10), 2);
    idle();

    // Table-driven lines
    for (int i = 0; i < 14; i++) begin
      sv10 = nv10; se10 = ne10; sv8 = nv8; se8 = ne8;
      for (int j = 0; j < tbl[i].n; j++) begin
        logic [47:0] bb;
        bb = tbl[i].bytes;
        feed(bb[47-8*j -: 8]);
      end
      idle();
      check($sformatf("vec%0d valid10", i), nv10 - sv10, tbl[i].v10);
      check($sformatf("vec%0d err10", i), ne10 - se10, tbl[i].e10);
      check($sformatf("vec%0d data10", i), int'(o_data10), tbl[i].d10);
      check($sformatf("vec%0d valid8", i), nv8 - sv8, tbl[i].v8);
      check($sformatf("vec%0d err8", i), ne8 - se8, tbl[i].e8);
      check($sformatf("vec%0d data8", i), int'(o_data8), tbl[i].d8);
    end

    // Reset mid-line discards the partial number
    feed("5");
    feed("6");
    rx_empty = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst o_data10", int'(o_data10), 0);
    check("midrst o_data8", int'(o_data8), 0);
    check("midrst o_valid10", int'(o_valid10), 0);
    check("midrst o_err10", int'(o_err10), 0);
    check("midrst rx_pop10", int'(rx_pop10), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sv10 = nv10; se10 = ne10;
    feed("1");
    feed(8'h0D);
    idle();
    check("postrst valid10", nv10 - sv10, 1);
    check("postrst err10", ne10 - se10, 0);
    check("postrst data10", int'(o_data10), 1);

`ifdef ECHO_EN
    // TX full blocks popping
    tx_full = 1'b1;
    rx_empty = 1'b0;
    rx_pop_data = "3";
    #1;
    check("echo stall rx_pop", int'(rx_pop10), 0);
    @(posedge clk); @(negedge clk);
    check("echo stall tx_push", int'(tx_push10), 0);
    tx_full = 1'b0;
    feed("3");
    check("echo push1", int'(tx_push10), 1);
    check("echo byte1", int'(tx_push_data10), 8'h33);
    feed(8'h0D);
    check("echo push2", int'(tx_push10), 1);
    check("echo byte2", int'(tx_push_data10), 8'h0D);
    check("echo parse data", int'(o_data10), 3);
    idle();
    check("echo push idle", int'(tx_push10), 0);
`else
    // Without echo, tx_full has no effect and nothing is pushed
    tx_full = 1'b1;
    feed("3");
    check("noecho tx_push", int'(tx_push10), 0);
    check("noecho tx_data", int'(tx_push_data10), 0);
    feed(8'h0D);
    check("noecho parse data", int'(o_data10), 3);
    tx_full = 1'b0;
    idle();
`endif

    check("valid and err overlap", nboth, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
